hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Issue controller for the ID stage: tracks in-flight register writes with per-register
//   pending counters, and raises 'hazard' to freeze IF/ID and bubble the ID control word.
//   Sits beside ID_stage. Issue is seen from ID outputs; retirement comes from the WB
//   write port (wb_wb_en/dest_wb), the same signals that drive the register file.
// PARAMETERS
//   REG_NUM_BITS  4   register index width
//   NUM_REGS      16  tracked registers (2**REG_NUM_BITS)
//   CNT_BITS      2   pending-counter width; max in-flight writes per register = 2**CNT_BITS-1
// PORTS
//   clk          in   1             rising-edge clock
//   rst          in   1             reset, asynchronous, active-low
//   id_valid     in   1             ID holds a real (non-bubble) instruction
//   id_src1      in   REG_NUM_BITS  first_src (Rn)
//   id_src2      in   REG_NUM_BITS  second_src (Rm/Rd)
//   id_two_src   in   1             id_src2 is read
//   id_wb_en     in   1             instruction writes id_dest
//   id_dest      in   REG_NUM_BITS  destination register
//   id_mem_r_en  in   1             instruction is a load
//   flush        in   1             branch taken; ID instruction killed this cycle
//   freeze       in   1             pipeline held (memory stall); no issue, no EXE advance
//   wb_wb_en     in   1             WB writes register file this cycle
//   dest_wb      in   REG_NUM_BITS  WB destination
//   hazard       out  1             stall ID (combinational)
//   busy         out  1             registered: any pending counter non-zero
//   sb_error     out  1             registered, sticky: retire of a register with count 0
// BEHAVIOUR
//   - Reset (rst=0): all counters 0; EXE tracker invalid; busy=0; sb_error=0; hazard forced 0.
//   - issue = id_valid & ~hazard & ~flush & ~freeze.
//   - Counter[id_dest] +1 on issue & id_wb_en.
//   - Counter[dest_wb] -1 on wb_wb_en.
//   - Increment and decrement of the same register in one cycle: count unchanged.
//   - Decrement when count==0: count stays 0; sb_error set and held until reset.
//   - raw = (cnt[id_src1]!=0) | (id_two_src & cnt[id_src2]!=0).
//   - sat = id_wb_en & (cnt[id_dest] == 2**CNT_BITS-1); saturation stalls, never wraps.
//   - hazard = id_valid & (raw_term | sat); zero-cycle latency from ID inputs and state.
//   - flush does not mask hazard but blocks issue. Bubbles (id_valid=0) never count.
//   - EXE tracker (1 entry: valid, dest, load):
//       - loads {issue & id_wb_en, id_dest, id_mem_r_en} when ~freeze;
//       - holds when freeze;
//       - becomes invalid when ~freeze and no issue.
//   - busy registered from next-state counters: 1 cycle after the count change.
//   - Reset mid-operation: all state cleared immediately; later WB writes of instructions
//     issued before reset set sb_error.
// CONFIGURATION
//   HAZARD_FWD_EN defined:
//     - forwarding unit present; raw_term = load-use only:
//         EXE valid & EXE load & (id_src1==EXE dest | id_two_src & id_src2==EXE dest).
//     - Counters still run; they drive sat, busy and sb_error.
//   HAZARD_FWD_EN undefined:
//     - raw_term = raw; stall until the producer's WB cycle.
//     - A consumer issues in the cycle after WB (register file writes on the clock edge).
// TESTING
//   1. Issue ADD R1 (wb_en, dest=1); next cycle SUB src1=1.
//        no FWD: hazard=1 until cycle after wb_wb_en&dest_wb=1, then issue.
//        FWD: hazard=0.
//   2. FWD: LDR R2 issued; next cycle src2=2, two_src=1 -> hazard=1 exactly 1 cycle.
//        With two_src=0 -> hazard=0.
//   3. Three back-to-back writes to R3 (CNT_BITS=2) -> cnt=3.
//        Fourth writer to R3 -> hazard=1 until one WB to R3.
//   4. Same cycle: issue writer of R4 and wb_wb_en dest_wb=4 with cnt[4]=1 -> cnt stays 1.
//        Then WB R4 -> cnt=0; busy drops next cycle.
//   5. wb_wb_en dest_wb=7 with cnt[7]=0 -> sb_error=1 next cycle, held.
//        flush with id_valid, id_wb_en -> no count change.
//   6. Assert rst low mid-stream with counts non-zero:
//        busy=0 and hazard=0 immediately; state stays cleared after release.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage issue scoreboard: per-register pending-write counters; hazard is combinational (0-cycle), busy/sb_error 1 cycle after the count change.
// Stalls ID via hazard on RAW or counter saturation; HAZARD_FWD_EN narrows RAW stalls to load-use against the EXE tracker.
module hazard_scoreboard #(
  parameter int REG_NUM_BITS = 4,
  parameter int NUM_REGS     = 16,
  parameter int CNT_BITS     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_NUM_BITS-1:0] id_src1,
  input  logic [REG_NUM_BITS-1:0] id_src2,
  input  logic                    id_two_src,
  input  logic                    id_wb_en,
  input  logic [REG_NUM_BITS-1:0] id_dest,
  input  logic                    id_mem_r_en,
  input  logic                    flush,
  input  logic                    freeze,
  input  logic                    wb_wb_en,
  input  logic [REG_NUM_BITS-1:0] dest_wb,
  output logic                    hazard,
  output logic                    busy,
  output logic                    sb_error
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0]     cnt_q [NUM_REGS];
  logic [CNT_BITS-1:0]     cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]     inc_v, dec_v;
  logic                    exe_vld_q, exe_vld_d;
  logic [REG_NUM_BITS-1:0] exe_dest_q, exe_dest_d;
  logic                    exe_load_q, exe_load_d;
  logic                    busy_q, busy_d;
  logic                    sb_error_q, sb_error_d;
  logic                    raw_term, sat, issue;

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load whose data is not back until MEM.
  assign raw_term = exe_vld_q & exe_load_q &
                    ((id_src1 == exe_dest_q) | (id_two_src & (id_src2 == exe_dest_q)));
`else
  assign raw_term = (cnt_q[id_src1] != '0) | (id_two_src & (cnt_q[id_src2] != '0));
  logic unused_exe;
  assign unused_exe = ^{exe_vld_q, exe_dest_q, exe_load_q};
`endif

  assign sat    = id_wb_en & (cnt_q[id_dest] == CNT_MAX);
  assign hazard = rst & id_valid & (raw_term | sat);
  assign issue  = id_valid & ~hazard & ~flush & ~freeze;

  always_comb begin
    busy_d     = 1'b0;
    sb_error_d = sb_error_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_v[r] = issue & id_wb_en & (id_dest == REG_NUM_BITS'(r));
      dec_v[r] = wb_wb_en & (dest_wb == REG_NUM_BITS'(r));
      cnt_d[r] = cnt_q[r];
      if (inc_v[r] && !dec_v[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_BITS'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        // Retiring a write we never saw issue: clamp at zero and flag it.
        if (cnt_q[r] == '0) sb_error_d = 1'b1;
        else                cnt_d[r]   = cnt_q[r] - CNT_BITS'(1);
      end
      busy_d = busy_d | (cnt_d[r] != '0);
    end
  end

  always_comb begin
    exe_vld_d  = exe_vld_q;
    exe_dest_d = exe_dest_q;
    exe_load_d = exe_load_q;
    if (!freeze) begin
      exe_vld_d  = issue & id_wb_en;
      exe_dest_d = id_dest;
      exe_load_d = id_mem_r_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      exe_vld_q  <= 1'b0;
      exe_dest_q <= '0;
      exe_load_q <= 1'b0;
      busy_q     <= 1'b0;
      sb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      exe_vld_q  <= exe_vld_d;
      exe_dest_q <= exe_dest_d;
      exe_load_q <= exe_load_d;
      busy_q     <= busy_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign busy     = busy_q;
  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations hold for both HAZARD_FWD_EN builds.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest, dest_wb;
  logic       flush, freeze, wb_wb_en;
  logic       hazard, busy, sb_error;
  int         checks = 0;
  int         errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze), .wb_wb_en(wb_wb_en),
    .dest_wb(dest_wb), .hazard(hazard), .busy(busy), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drv(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic [3:0] d, input logic mr);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_dest = d; id_mem_r_en = mr;
    #1;
  endtask

  task automatic wb_drv(input logic en, input logic [3:0] d);
    wb_wb_en = en; dest_wb = d;
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; wb_wb_en = 1'b0; dest_wb = '0;
    id_drv(1, 0, 0, 0, 1, 0, 0);
    repeat (2) tick();
    chk("reset_hazard", hazard, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", sb_error, 1'b0);
    rst = 1'b1;
    id_drv(0, 0, 0, 0, 0, 0, 0);

    // 1: ADD R1 then a consumer of R1
    id_drv(1, 5, 6, 0, 1, 1, 0);
    chk("t1_add_issue", hazard, 1'b0);
    tick();
    chk("t1_busy", busy, 1'b1);
    id_drv(1, 1, 0, 0, 1, 8, 0);
`ifdef HAZARD_FWD_EN
    chk("t1_fwd_nohaz", hazard, 1'b0);
    tick();
    id_drv(0, 0, 0, 0, 0, 0, 0);
    wb_drv(1, 1); tick();
    wb_drv(1, 8); tick();
    wb_drv(0, 0);
`else
    chk("t1_raw", hazard, 1'b1);
    tick();
    chk("t1_raw_hold", hazard, 1'b1);
    wb_drv(1, 1);
    chk("t1_raw_wbcycle", hazard, 1'b1);
    tick();
    wb_drv(0, 0);
    chk("t1_after_wb", hazard, 1'b0);
    tick();
    id_drv(0, 0, 0, 0, 0, 0, 0);
    wb_drv(1, 8); tick();
    wb_drv(0, 0);
`endif
    chk("t1_busy_clear", busy, 1'b0);

    // 2: load then consumer through src2
    id_drv(1, 0, 0, 0, 1, 2, 1);
    chk("t2_ldr", hazard, 1'b0);
    tick();
    id_drv(1, 0, 2, 1, 1, 10, 0);
    chk("t2_use", hazard, 1'b1);
    tick();
`ifdef HAZARD_FWD_EN
    chk("t2_use_one_cycle", hazard, 1'b0);
`else
    chk("t2_use_hold", hazard, 1'b1);
    wb_drv(1, 2); tick();
    wb_drv(0, 0);
    chk("t2_use_release", hazard, 1'b0);
`endif
    tick();
    id_drv(1, 0, 0, 0, 1, 2, 1);
    chk("t2_ldr2", hazard, 1'b0);
    tick();
    id_drv(1, 0, 2, 0, 0, 0, 0);
    chk("t2_two_src_off", hazard, 1'b0);
    tick();
    id_drv(0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    wb_drv(1, 2); tick();
`endif
    wb_drv(1, 2); tick();
    wb_drv(1, 10); tick();
    wb_drv(0, 0);
    chk("t2_busy_clear", busy, 1'b0);
    chk("t2_no_err", sb_error, 1'b0);

    // 3: saturation of R3
    id_drv(1, 0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_fill", hazard, 1'b0);
      tick();
    end
    chk("t3_sat", hazard, 1'b1);
    tick();
    chk("t3_sat_hold", hazard, 1'b1);
    wb_drv(1, 3);
    chk("t3_sat_wbcycle", hazard, 1'b1);
    tick();
    wb_drv(0, 0);
    chk("t3_sat_release", hazard, 1'b0);
    tick();
    id_drv(0, 0, 0, 0, 0, 0, 0);
    wb_drv(1, 3);
    repeat (2) tick();
    chk("t3_busy_mid", busy, 1'b1);
    tick();
    wb_drv(0, 0);
    chk("t3_busy_clear", busy, 1'b0);

    // 4: simultaneous issue and retire of R4
    id_drv(1, 0, 0, 0, 1, 4, 0);
    tick();
    wb_drv(1, 4);
    chk("t4_same_cycle", hazard, 1'b0);
    tick();
    id_drv(0, 0, 0, 0, 0, 0, 0);
    wb_drv(0, 0);
    chk("t4_busy_hold", busy, 1'b1);
    chk("t4_no_err", sb_error, 1'b0);
    wb_drv(1, 4); tick();
    wb_drv(0, 0);
    chk("t4_busy_drop", busy, 1'b0);
    chk("t4_no_err2", sb_error, 1'b0);

    // 5: retire with zero count, then flush/freeze never count
    wb_drv(1, 7); tick();
    wb_drv(0, 0);
    chk("t5_err_set", sb_error, 1'b1);
    tick();
    chk("t5_err_hold", sb_error, 1'b1);
    chk("t5_busy", busy, 1'b0);
    flush = 1'b1;
    id_drv(1, 0, 0, 0, 1, 9, 0);
    chk("t5_flush_haz", hazard, 1'b0);
    tick();
    flush = 1'b0;
    chk("t5_flush_nocount", busy, 1'b0);
    freeze = 1'b1;
    #1;
    tick();
    freeze = 1'b0;
    id_drv(0, 0, 0, 0, 0, 0, 0);
    chk("t5_freeze_nocount", busy, 1'b0);

    // 6: asynchronous reset mid-stream
    id_drv(1, 0, 0, 0, 1, 5, 0); tick();
    id_drv(1, 0, 0, 0, 1, 6, 0); tick();
    id_drv(1, 5, 0, 0, 0, 0, 0);
    chk("t6_busy", busy, 1'b1);
`ifndef HAZARD_FWD_EN
    chk("t6_raw", hazard, 1'b1);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_hazard", hazard, 1'b0);
    chk("t6_rst_err", sb_error, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_post_hazard", hazard, 1'b0);
    tick();
    chk("t6_post_busy", busy, 1'b0);
    id_drv(0, 0, 0, 0, 0, 0, 0);
    wb_drv(1, 5); tick();
    wb_drv(0, 0);
    chk("t6_stale_wb_err", sb_error, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
